tdm_slot_arbiter: RTL
=====================

Name: tdm_slot_arbiter

Overview:
- Parametrised successor to the fixed 16-port static arbiter placed in front of the pipelined data transport network.
- Each of N blocking input channels is buffered in a DEPTH-entry FIFO. Messages are issued onto N non-blocking output channels under a rotating time-division schedule.
- The schedule guarantees that no two inputs target the same destination in one cycle, so the downstream network never sees collisions.
- Replaces the static arbiter in the combined arbiter+network wrappers for any port count.

Parameters:
- N, 16, number of input/output channels (2..64, need not be a power of two).
- ADDR_WIDTH, 4, destination address width; requires N <= 2**ADDR_WIDTH.
- DATA_WIDTH, 64, payload width.
- DEPTH, 4, entries per input FIFO (power of two, >= 2).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  N  per-input message valid.
- in_ready  out  N  per-input ready (blocking consumer side).
- in_addr  in  N*ADDR_WIDTH  per-input destination; channel i occupies slice i.
- in_data  in  N*DATA_WIDTH  per-input payload.
- out_valid  out  N  per-output valid (non-blocking producer; no ready).
- out_addr  out  N*ADDR_WIDTH  destination of the issued message.
- out_data  out  N*DATA_WIDTH  payload of the issued message.
- slot  out  ADDR_WIDTH  current schedule slot.
- addr_err  out  N  sticky per-input illegal-address flag.

Behaviour:
- Reset (async assert, sync release), all outputs:
  - in_ready=0 while reset_n=0; =1 from the first edge after release.
  - out_valid=0, out_addr=0, out_data=0, slot=0, addr_err=0.
  - All FIFOs empty.
- Input handshake:
  - Transfer on any edge with in_valid[i]&in_ready[i].
  - in_ready[i] = FIFO i count < DEPTH, derived from registered count only. No combinational path from pop to ready, so a full FIFO does not accept even when a pop occurs in the same cycle.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
- Illegal address:
  - A transfer with in_addr >= N is accepted (ready honoured) but not written.
  - addr_err[i] is set and stays sticky until reset.
- Slot counter:
  - Increments every cycle after reset; wraps from N-1 to 0.
- Issue rule, evaluated each cycle per input i:
  - The head of FIFO i is eligible iff FIFO i is non-empty and head.addr == (i + slot) mod N.
  - If eligible, the head is popped at the edge and registered onto out channel i: out_valid[i]=1, out_addr/out_data = head, for exactly one cycle. Otherwise out_valid[i]=0 and out_addr/out_data hold their previous values.
  - The schedule is a permutation, so at most one input per destination per cycle; no further arbitration is needed.
- Head-of-line:
  - A non-eligible head blocks its FIFO; later entries wait.
  - Worst-case wait is N-1 cycles per message.
- Latency:
  - Minimum 2 cycles from the input handshake edge to out_valid. Entry visible at head in the cycle after the push; issued at the next edge if the slot matches.
  - Maximum 2+(N-1) cycles for an empty FIFO.
  - A full FIFO sustains 1 message per N cycles in the worst case and 1 per cycle for the diagonal pattern addr=(i+slot) mod N.
- Reset mid-operation:
  - All FIFO contents are discarded, outputs go to reset values immediately, and in-flight outputs are dropped.
- Out channel i carries only input i's messages; the downstream network routes by out_addr.

Optional Feature:
- Macro: TDM_SLOT_ARBITER_STATS_EN.
- With the macro defined:
  - Added ports: stat_sel (in, clog2(N)), stat_issued (out, 32), stat_blocked (out, 32).
  - Per input there are two 32-bit saturating counters:
    - issued: pops.
    - blocked: cycles with a non-empty FIFO whose head is not eligible.
  - stat_* are a combinational read of the counters for input stat_sel; a stat_sel >= N reads 0.
  - Counters reset to 0 on reset_n and saturate at 0xFFFFFFFF.
- Without the macro: the ports and counters do not exist, and the behaviour above is unchanged.

Test Plan (N=4, DEPTH=4, DATA_WIDTH=64 unless stated):
- Reset release, then input 0 sends addr=1, data=0xA5 on the edge where slot=0.
  - Issued when slot=1.
  - out_valid[0]=1 one cycle, out_addr=1, out_data=0xA5; latency 2 cycles.
- Input 2 sends 5 back-to-back messages, all addr=2.
  - in_ready[2] drops after 4 accepts.
  - One issue per 4 cycles, at slot=0; output order matches input order.
- All 4 inputs push continuously with addr=(i+slot+1) mod 4, i.e. aligned to the next slot.
  - All out_valid high every cycle after fill; never two with the same out_addr in one cycle.
- Input 1 sends addr=7 (>= N).
  - Accepted, no out_valid[1], addr_err[1]=1 and stays 1.
  - A following addr=0 message still issues normally.
- Fill FIFO 3 with 3 entries, assert reset_n=0 mid-cycle.
  - out_valid=0, slot=0 immediately.
  - After release: no stale output, in_ready=1111.
- With TDM_SLOT_ARBITER_STATS_EN, input 0 holds a head addr=3 from slot=0.
  - stat_sel=0 reads blocked=3 at issue, then issued=1.

Source files
------------

// File: rtl/tdm_slot_arbiter.sv
// tdm_slot_arbiter: N buffered input channels issued onto N output channels
// under a rotating time-division schedule. In slot s, input i may only issue
// a head whose destination is (i + s) mod N, so destinations never collide.
// Optional per-input issue/blocked counters: define TDM_SLOT_ARBITER_STATS_EN.
module tdm_slot_arbiter #(
   parameter int N          = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [N-1:0]               in_valid,
   output logic [N-1:0]               in_ready,
   input  logic [N*ADDR_WIDTH-1:0]    in_addr,
   input  logic [N*DATA_WIDTH-1:0]    in_data,
   output logic [N-1:0]               out_valid,
   output logic [N*ADDR_WIDTH-1:0]    out_addr,
   output logic [N*DATA_WIDTH-1:0]    out_data,
   output logic [ADDR_WIDTH-1:0]      slot,
   output logic [N-1:0]               addr_err
`ifdef TDM_SLOT_ARBITER_STATS_EN
   ,
   input  logic [$clog2(N)-1:0]       stat_sel,
   output logic [31:0]                stat_issued,
   output logic [31:0]                stat_blocked
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_WIDTH:0] N_W   = (ADDR_WIDTH+1)'(N);
   localparam logic [CW-1:0]       DEPTH_W = CW'(DEPTH);

   // Ready is held low until the first edge after reset release.
   logic live;

   // Mark the arbiter live one edge after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) live <= 1'b0;
      else          live <= 1'b1;
   end

   // Rotating schedule slot, 0..N-1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                            slot <= '0;
      else if (slot == ADDR_WIDTH'(N - 1))     slot <= '0;
      else                                     slot <= slot + 1'b1;
   end

`ifdef TDM_SLOT_ARBITER_STATS_EN
   logic [31:0] issued_arr  [N];
   logic [31:0] blocked_arr [N];
`endif

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
      logic [DATA_WIDTH-1:0] mem_data [DEPTH];
      logic [PW-1:0]         wr_ptr, rd_ptr;
      logic [CW-1:0]         count;
      logic [ADDR_WIDTH-1:0] a, head_a;
      logic [DATA_WIDTH-1:0] head_d;
      logic [ADDR_WIDTH:0]   target_sum, target;
      logic                  accept, legal, push, pop;
      logic                  ov, err;
      logic [ADDR_WIDTH-1:0] oa;
      logic [DATA_WIDTH-1:0] od;

      assign a          = in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign in_ready[i] = live && (count < DEPTH_W);
      assign accept     = in_valid[i] & in_ready[i];
      assign legal      = {1'b0, a} < N_W;
      assign push       = accept & legal;
      assign head_a     = mem_addr[rd_ptr];
      assign head_d     = mem_data[rd_ptr];
      assign target_sum = (ADDR_WIDTH+1)'(i) + {1'b0, slot};
      assign target     = (target_sum >= N_W) ? (target_sum - N_W) : target_sum;
      assign pop        = (count != '0) && ({1'b0, head_a} == target);

      // FIFO storage write; illegal destinations are dropped here.
      always_ff @(posedge clock) begin
         if (push) begin
            mem_addr[wr_ptr] <= a;
            mem_data[wr_ptr] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      // FIFO pointers and occupancy.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end

      // Register the issued head; address/data hold when nothing issues.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            ov <= 1'b0;
            oa <= '0;
            od <= '0;
         end else begin
            ov <= pop;
            if (pop) begin
               oa <= head_a;
               od <= head_d;
            end
         end
      end

      // Sticky illegal-destination flag.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n)              err <= 1'b0;
         else if (accept && !legal) err <= 1'b1;
      end

      assign out_valid[i]                          = ov;
      assign out_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = oa;
      assign out_data[i*DATA_WIDTH +: DATA_WIDTH]  = od;
      assign addr_err[i]                           = err;

`ifdef TDM_SLOT_ARBITER_STATS_EN
      logic [31:0] cnt_issued, cnt_blocked;

      // Saturating issue and head-blocked cycle counters.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            cnt_issued  <= '0;
            cnt_blocked <= '0;
         end else begin
            if (pop && cnt_issued != 32'hFFFF_FFFF)
               cnt_issued <= cnt_issued + 1'b1;
            if ((count != '0) && !pop && cnt_blocked != 32'hFFFF_FFFF)
               cnt_blocked <= cnt_blocked + 1'b1;
         end
      end

      assign issued_arr[i]  = cnt_issued;
      assign blocked_arr[i] = cnt_blocked;
`endif
   end

`ifdef TDM_SLOT_ARBITER_STATS_EN
   // Combinational counter read; out-of-range selects read zero.
   always_comb begin
      stat_issued  = '0;
      stat_blocked = '0;
      if (32'(stat_sel) < 32'(N)) begin
         stat_issued  = issued_arr[stat_sel];
         stat_blocked = blocked_arr[stat_sel];
      end
   end
`endif

endmodule
